// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the byte-wide
// instruction memory it feeds.
package imem_pkg;

    localparam int BYTES_PER_WORD   = 4;
    localparam int IMEM_DEPTH_BYTES = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_WORD = 2'd1,
        ST_WRITE     = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// Serialises 32-bit instruction words from a valid/ready stream into four
// little-endian byte writes, holding the CPU off fetch while a load runs.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH_BYTES = IMEM_DEPTH_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    input  logic        word_last,
    output logic        word_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [31:0] words_loaded
);

    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_BYTES);
    localparam logic [31:0] WORD_STEP   = 32'(BYTES_PER_WORD);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] ptr_q;
    logic [1:0]  idx_q;
    logic [31:0] word_q;
    logic        last_q;
    logic        err_q;
    logic [31:0] cnt_q;

    logic [31:0] start_aligned;
    logic        start_ovf;
    logic [31:0] ptr_next;
    logic        byte_last;
    logic        limit_hit;

    assign start_aligned = start_addr & ~32'h3;
    assign start_ovf     = (start_aligned >= DEPTH_LIMIT);
    assign ptr_next      = ptr_q + WORD_STEP;
    assign byte_last     = (idx_q == 2'd3);
    assign limit_hit     = (ptr_next == DEPTH_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = (state_q != ST_IDLE);
        cpu_hold   = (state_q != ST_IDLE);
        done       = 1'b0;
        err        = err_q;
        words_loaded = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = start_ovf ? ST_DONE : ST_WAIT_WORD;
                end
            end
            ST_WAIT_WORD: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = ptr_q + 32'(idx_q);
                mem_wdata = word_q[{idx_q, 3'b000} +: 8];
                if (byte_last) begin
                    state_d = (last_q || limit_hit) ? ST_DONE : ST_WAIT_WORD;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers: pointer, byte index, last flag, error and word count.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ptr_q <= start_aligned;
                        err_q <= start_ovf;
                        cnt_q <= '0;
                    end
                end
                ST_WAIT_WORD: begin
                    if (word_valid) begin
                        last_q <= word_last;
                        idx_q  <= '0;
                    end
                end
                ST_WRITE: begin
                    idx_q <= idx_q + 2'd1;
                    if (byte_last) begin
                        ptr_q <= ptr_next;
                        cnt_q <= cnt_q + 32'd1;
                        // A word flagged last ends cleanly even if it fills memory.
                        err_q <= !last_q && limit_hit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Word holding register is pure data; output gating hides it outside WRITE.
    always_ff @(posedge clk) begin
        if (state_q == ST_WAIT_WORD && word_valid) begin
            word_q <= word_data;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected byte writes are queued as words are
// offered and compared against mem_we/mem_addr/mem_wdata as they appear.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] start_addr;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [31:0] words_loaded;

    int          checks = 0;
    int          passed = 0;
    logic [39:0] sb[$];
    logic [31:0] exp_ptr = '0;

    imem_loader #(.DEPTH_BYTES(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_last   (word_last),
        .word_ready  (word_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Byte-write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [39:0] ent;
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
            end else begin
                ent = sb.pop_front();
                chk("waddr", mem_addr, ent[39:8]);
                chk("wdata", {24'd0, mem_wdata}, {24'd0, ent[7:0]});
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_word_ready"}, 32'(word_ready), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_words_loaded"}, words_loaded, 0);
    endtask

    task automatic do_start(input logic [31:0] addr);
        start      = 1'b1;
        start_addr = addr;
        exp_ptr    = addr & ~32'h3;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers a word, queues its first nb expected bytes, returns on the
    // cycle after the handshake (byte 0 should be on the bus).
    task automatic send_word(input logic [31:0] data, input logic last, input int nb);
        int got;
        for (int i = 0; i < nb; i++) begin
            sb.push_back({exp_ptr + 32'(i), data[8*i +: 8]});
        end
        exp_ptr    = exp_ptr + 32'd4;
        word_data  = data;
        word_last  = last;
        word_valid = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            if (word_ready === 1'b1) got = 1;
            @(negedge clk);
        end
        word_valid = 1'b0;
        chk("handshake", 32'(got), 1);
        if (got != 0) chk("hs_to_we", 32'(mem_we), 1);
    endtask

    // Called on the byte-0 cycle of the final word.
    task automatic wait_done(input string tag, input logic exp_err, input logic [31:0] exp_cnt);
        int n;
        n = 0;
        while (n < 20 && done !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_latency"}, 32'(n), 4);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_words_loaded"}, words_loaded, exp_cnt);
        chk({tag, "_busy_at_done"}, 32'(busy), 1);
        @(negedge clk);
        chk({tag, "_done_once"}, 32'(done), 0);
        chk({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        int saw_ready;
        int done_cnt;
        logic err_at_done;

        reset      = 1'b1;
        start      = 1'b1;
        start_addr = 32'h10;
        word_valid = 1'b0;
        word_data  = '0;
        word_last  = 1'b0;

        // Reset with and without start
        repeat (2) begin
            @(negedge clk);
            check_idle("rst_start");
        end
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_idle("rst");
        end
        reset = 1'b0;
        @(negedge clk);
        check_idle("idle");

        // Single word
        do_start(32'h0);
        chk("single_ready", 32'(word_ready), 1);
        chk("single_hold", 32'(cpu_hold), 1);
        send_word(32'h8C22_0004, 1'b1, 4);
        wait_done("single", 1'b0, 32'd1);

        // Stalled stream from unaligned start
        do_start(32'h13);
        send_word(32'h1122_3344, 1'b0, 4);
        repeat (6) @(negedge clk);
        send_word(32'h5566_7788, 1'b0, 4);
        repeat (6) @(negedge clk);
        send_word(32'h99AA_BBCC, 1'b1, 4);
        wait_done("stall", 1'b0, 32'd3);

        // Overflow at the top of memory; third word must never be accepted
        do_start(32'd24);
        send_word(32'hA0A1_A2A3, 1'b0, 4);
        send_word(32'hB0B1_B2B3, 1'b0, 4);
        word_data  = 32'hC0C1_C2C3;
        word_last  = 1'b0;
        word_valid = 1'b1;
        saw_ready   = 0;
        done_cnt    = 0;
        err_at_done = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (word_ready === 1'b1) saw_ready = 1;
            if (done === 1'b1) begin
                done_cnt++;
                err_at_done = err;
            end
            @(negedge clk);
        end
        word_valid = 1'b0;
        chk("ovf_no_ready", 32'(saw_ready), 0);
        chk("ovf_done_count", 32'(done_cnt), 1);
        chk("ovf_err", 32'(err_at_done), 1);
        chk("ovf_words", words_loaded, 2);

        do_start(32'd32);
        chk("ovf_start_done", 32'(done), 1);
        chk("ovf_start_err", 32'(err), 1);
        chk("ovf_start_ready", 32'(word_ready), 0);
        chk("ovf_start_words", words_loaded, 0);
        @(negedge clk);
        chk("ovf_start_idle", 32'(busy), 0);
        chk("ovf_err_sticky", 32'(err), 1);

        // Reset after byte 1 of the second word
        do_start(32'h0);
        chk("restart_err_clr", 32'(err), 0);
        send_word(32'h1357_9BDF, 1'b0, 4);
        send_word(32'h2468_ACE0, 1'b0, 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_we", 32'(mem_we), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_words", words_loaded, 0);
        reset = 1'b0;
        @(negedge clk);
        do_start(32'h8);
        send_word(32'hDEAD_BEEF, 1'b1, 4);
        wait_done("after_rst", 1'b0, 32'd1);

        // Start pulsed during WRITE is ignored
        do_start(32'h0);
        send_word(32'h0102_0304, 1'b0, 4);
        start      = 1'b1;
        start_addr = 32'h10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("five_cycle_ready", 32'(word_ready), 1);
        send_word(32'h0506_0708, 1'b1, 4);
        wait_done("busy_start", 1'b0, 32'd2);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
